frame_region_fill: RTL and testbench

//  Parametrised frame-buffer fill engine, successor to the full-frame clear sequencer.

---
 rtl/frame_region_fill.sv | 153 +++++++++++++++
 tb/tb_frame_region_fill.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_region_fill.sv
// frame_region_fill: writes one constant colour into every pixel of a rectangle
// of the frame buffer. Uses a start/done level handshake, honours write
// back-pressure and can be aborted while filling.
module frame_region_fill #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int COLOR_W = 16,
    parameter int ADDR_W  = 19
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               fill_start,
    input  logic               fill_abort,
    input  logic [X_W-1:0]     x0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y0,
    input  logic [Y_W-1:0]     y1,
    input  logic [COLOR_W-1:0] fill_color,
    input  logic               mem_ready,
    output logic [X_W-1:0]     DrawX,
    output logic [Y_W-1:0]     DrawY,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    output logic               mem_we,
    output logic               busy,
    output logic               fill_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [X_W-1:0]    X_MAX    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

    state_t r_state;
    state_t w_nextState;

    logic [X_W-1:0]     r_xa;
    logic [X_W-1:0]     r_xb;
    logic [Y_W-1:0]     r_yb;
    logic [X_W-1:0]     r_drawX;
    logic [Y_W-1:0]     r_drawY;
    logic [ADDR_W-1:0]  r_rowBase;
    logic [COLOR_W-1:0] r_color;

    logic [X_W-1:0]    w_xLo;
    logic [X_W-1:0]    w_xHi;
    logic [Y_W-1:0]    w_yLo;
    logic [Y_W-1:0]    w_yHi;
    logic [X_W-1:0]    w_xa;
    logic [X_W-1:0]    w_xb;
    logic [Y_W-1:0]    w_ya;
    logic [Y_W-1:0]    w_yb;
    logic [ADDR_W-1:0] w_rowBaseStart;
    logic              w_accept;
    logic              w_lastX;
    logic              w_lastY;

    // Corners may arrive in any order; order first, then clamp into the frame.
    assign w_xLo = (x0 < x1) ? x0 : x1;
    assign w_xHi = (x0 < x1) ? x1 : x0;
    assign w_yLo = (y0 < y1) ? y0 : y1;
    assign w_yHi = (y0 < y1) ? y1 : y0;
    assign w_xa  = (w_xLo > X_MAX) ? X_MAX : w_xLo;
    assign w_xb  = (w_xHi > X_MAX) ? X_MAX : w_xHi;
    assign w_ya  = (w_yLo > Y_MAX) ? Y_MAX : w_yLo;
    assign w_yb  = (w_yHi > Y_MAX) ? Y_MAX : w_yHi;

    // The only multiply: row base of the first line, taken once at start.
    assign w_rowBaseStart = ADDR_W'(w_ya) * ROW_STEP;

    assign w_accept = (r_state == S_FILL) && mem_ready;
    assign w_lastX  = (r_drawX == r_xb);
    assign w_lastY  = (r_drawY == r_yb);

    // State register with asynchronous reset back to IDLE.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; abort takes priority over completing the last pixel.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (fill_start) begin
                    w_nextState = S_FILL;
                end
            end
            S_FILL: begin
                if (fill_abort) begin
                    w_nextState = S_IDLE;
                end else if (w_accept && w_lastX && w_lastY) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                if (!fill_start) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Latch the rectangle at start, then walk pixels one accepted write at a time.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_xa      <= '0;
            r_xb      <= '0;
            r_yb      <= '0;
            r_drawX   <= '0;
            r_drawY   <= '0;
            r_rowBase <= '0;
            r_color   <= '0;
        end else if (r_state == S_IDLE && fill_start) begin
            r_xa      <= w_xa;
            r_xb      <= w_xb;
            r_yb      <= w_yb;
            r_drawX   <= w_xa;
            r_drawY   <= w_ya;
            r_rowBase <= w_rowBaseStart;
            r_color   <= fill_color;
        end else if (w_accept && !fill_abort) begin
            if (!w_lastX) begin
                r_drawX <= r_drawX + X_W'(1);
            end else if (!w_lastY) begin
                r_drawX   <= r_xa;
                r_drawY   <= r_drawY + Y_W'(1);
                r_rowBase <= r_rowBase + ROW_STEP;
            end
        end
    end

    assign DrawX     = r_drawX;
    assign DrawY     = r_drawY;
    assign mem_addr  = r_rowBase + ADDR_W'(r_drawX);
    assign mem_data  = r_color;
    assign mem_we    = (r_state == S_FILL);
    assign busy      = (r_state == S_FILL);
    assign fill_done = (r_state == S_DONE);

endmodule

// File: tb/tb_frame_region_fill.sv
// Testbench for frame_region_fill: scoreboard of expected writes, drained by a
// monitor that compares every presented write against the queue front.
module tb_frame_region_fill;

    localparam int XW = 10;
    localparam int YW = 10;
    localparam int CW = 16;
    localparam int AW = 19;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          fill_start = 1'b0;
    logic          fill_abort = 1'b0;
    logic [XW-1:0] x0 = '0;
    logic [XW-1:0] x1 = '0;
    logic [YW-1:0] y0 = '0;
    logic [YW-1:0] y1 = '0;
    logic [CW-1:0] fill_color = '0;
    logic          mem_ready = 1'b1;
    logic [XW-1:0] DrawX;
    logic [YW-1:0] DrawY;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_data;
    logic          mem_we;
    logic          busy;
    logic          fill_done;

    frame_region_fill dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .fill_start(fill_start),
        .fill_abort(fill_abort),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .fill_color(fill_color),
        .mem_ready (mem_ready),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .busy      (busy),
        .fill_done (fill_done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } wr_t;

    wr_t expQ[$];
    wr_t monEntry;
    int  total = 0;
    int  bad = 0;
    int  cycleCnt = 0;
    int  lastPopCycle = -10;
    int  acceptCount = 0;
    int  doneCycle = 0;
    bit  doneSeen = 1'b0;

    // Monitor: every presented write must match the queue front; pop on accept.
    always @(negedge Clk) begin
        cycleCnt++;
        if (fill_done && !doneSeen) begin
            doneSeen  = 1'b1;
            doneCycle = cycleCnt;
        end
        if (!Reset && mem_we) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_write: got x=%0d y=%0d addr=%0d data=%h, expected no write",
                         DrawX, DrawY, mem_addr, mem_data);
            end else begin
                monEntry = expQ[0];
                if (DrawX !== monEntry.x || DrawY !== monEntry.y ||
                    mem_addr !== monEntry.addr || mem_data !== monEntry.data) begin
                    bad++;
                    $display("[TB] FAIL %s: got x=%0d y=%0d addr=%0d data=%h, expected x=%0d y=%0d addr=%0d data=%h",
                             mem_ready ? "write" : "stall_hold", DrawX, DrawY, mem_addr, mem_data,
                             monEntry.x, monEntry.y, monEntry.addr, monEntry.data);
                end
                if (mem_ready) begin
                    void'(expQ.pop_front());
                    lastPopCycle = cycleCnt;
                    acceptCount++;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushOne(input int x, input int y, input int addr, input int data);
        wr_t e;
        e.x    = XW'(x);
        e.y    = YW'(y);
        e.addr = AW'(addr);
        e.data = CW'(data);
        expQ.push_back(e);
    endtask

    task automatic pushRect(input int xa, input int xb, input int ya, input int yb, input int data);
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                pushOne(x, y, y * 640 + x, data);
            end
        end
    endtask

    // Presents the rectangle, lets one edge sample start, and checks the first write is up.
    task automatic applyStimulus(input int ax0, input int ax1, input int ay0, input int ay1,
                                 input int color, input bit holdStart, input int firstX);
        @(posedge Clk);
        #1;
        x0         = XW'(ax0);
        x1         = XW'(ax1);
        y0         = YW'(ay0);
        y1         = YW'(ay1);
        fill_color = CW'(color);
        fill_start = 1'b1;
        doneSeen   = 1'b0;
        @(posedge Clk);
        #1;
        if (!holdStart) fill_start = 1'b0;
        checkOutput("first_we", int'(mem_we), 1);
        checkOutput("first_x", int'(DrawX), firstX);
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!doneSeen && n < budget) begin
            @(posedge Clk);
            n++;
        end
        #1;
        checkOutput("done_seen", int'(doneSeen), 1);
        if (doneSeen) checkOutput("done_latency", doneCycle, lastPopCycle + 1);
        checkOutput("queue_empty", expQ.size(), 0);
    endtask

    initial begin
        int base;
        int n;

        // Asynchronous reset with no clock edge involved.
        #1;
        Reset = 1'b1;
        #1;
        checkOutput("reset_we", int'(mem_we), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(fill_done), 0);
        checkOutput("reset_addr", int'(mem_addr), 0);
        checkOutput("reset_data", int'(mem_data), 0);
        checkOutput("reset_x", int'(DrawX), 0);
        checkOutput("reset_y", int'(DrawY), 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (2) @(posedge Clk);

        // Small rectangle, start held high to exercise the done handshake.
        pushOne(10, 5, 3210, 16'hF800);
        pushOne(11, 5, 3211, 16'hF800);
        pushOne(12, 5, 3212, 16'hF800);
        pushOne(10, 6, 3850, 16'hF800);
        pushOne(11, 6, 3851, 16'hF800);
        pushOne(12, 6, 3852, 16'hF800);
        applyStimulus(10, 12, 5, 6, 16'hF800, 1'b1, 10);
        waitDone(50);
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("done_hold", int'(fill_done), 1);
        checkOutput("done_we", int'(mem_we), 0);
        checkOutput("done_x", int'(DrawX), 12);
        checkOutput("done_y", int'(DrawY), 6);
        fill_start = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("done_release", int'(fill_done), 0);
        checkOutput("idle_busy", int'(busy), 0);

        // Swapped and out-of-frame corners.
        pushOne(638, 2, 1918, 16'h1234);
        pushOne(639, 2, 1919, 16'h1234);
        applyStimulus(700, 638, 2, 2, 16'h1234, 1'b0, 638);
        waitDone(50);

        // Back-pressure: ready alternates every cycle during the fill.
        pushOne(10, 5, 3210, 16'h001F);
        pushOne(11, 5, 3211, 16'h001F);
        pushOne(12, 5, 3212, 16'h001F);
        pushOne(10, 6, 3850, 16'h001F);
        pushOne(11, 6, 3851, 16'h001F);
        pushOne(12, 6, 3852, 16'h001F);
        applyStimulus(12, 10, 6, 5, 16'h001F, 1'b0, 10);
        n = 0;
        while (!doneSeen && n < 60) begin
            mem_ready = ~mem_ready;
            @(posedge Clk);
            #1;
            n++;
        end
        mem_ready = 1'b1;
        waitDone(10);

        // Abort after 100 accepted writes; the write in the abort cycle still counts.
        pushRect(0, 639, 0, 1, 16'hAAAA);
        base = acceptCount;
        applyStimulus(0, 639, 0, 1, 16'hAAAA, 1'b0, 0);
        n = 0;
        while ((acceptCount - base) < 100 && n < 300) begin
            @(posedge Clk);
            n++;
        end
        #1;
        checkOutput("abort_reach100", acceptCount - base, 100);
        fill_abort = 1'b1;
        @(posedge Clk);
        #1;
        fill_abort = 1'b0;
        checkOutput("abort_we", int'(mem_we), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_accepts", acceptCount - base, 101);
        checkOutput("abort_x", int'(DrawX), 100);
        checkOutput("abort_y", int'(DrawY), 0);
        expQ.delete();
        repeat (5) @(posedge Clk);
        #1;
        checkOutput("abort_no_done", int'(doneSeen), 0);

        // New fill after abort.
        pushOne(10, 5, 3210, 16'h07E0);
        pushOne(11, 5, 3211, 16'h07E0);
        pushOne(12, 5, 3212, 16'h07E0);
        pushOne(10, 6, 3850, 16'h07E0);
        pushOne(11, 6, 3851, 16'h07E0);
        pushOne(12, 6, 3852, 16'h07E0);
        applyStimulus(10, 12, 6, 5, 16'h07E0, 1'b0, 10);
        waitDone(50);

        // Bottom-right corner block ending on the last frame address.
        pushRect(600, 639, 440, 479, 16'h5A5A);
        applyStimulus(639, 600, 479, 440, 16'h5A5A, 1'b0, 600);
        waitDone(2000);
        checkOutput("corner_last_x", int'(DrawX), 639);
        checkOutput("corner_last_y", int'(DrawY), 479);
        checkOutput("corner_last_addr", int'(mem_addr), 307199);

        // Reset between clock edges in the middle of a fill.
        pushRect(0, 639, 3, 3, 16'hBEEF);
        applyStimulus(0, 639, 3, 3, 16'hBEEF, 1'b0, 0);
        repeat (4) @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        checkOutput("midreset_we", int'(mem_we), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_x", int'(DrawX), 0);
        checkOutput("midreset_y", int'(DrawY), 0);
        expQ.delete();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("postreset_busy", int'(busy), 0);
        checkOutput("postreset_we", int'(mem_we), 0);

        // Fill still works after the reset.
        pushOne(638, 2, 1918, 16'h4321);
        pushOne(639, 2, 1919, 16'h4321);
        applyStimulus(638, 1000, 2, 2, 16'h4321, 1'b0, 638);
        waitDone(50);

        repeat (3) @(posedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
